// File: rtl/stream_mux_nch.sv
// stream_mux_nch: N-channel valid/ready stream multiplexer with a one-beat registered output stage.
// Fixed-select or round-robin grant; define STREAM_MUX_LAST_LOCK_EN for packet-locked arbitration.
module stream_mux_nch #(
    parameter int WIDTH     = 16,
    parameter int NUM_CH    = 4,
    parameter int SEL_WIDTH = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
`ifdef STREAM_MUX_LAST_LOCK_EN
    input  logic [NUM_CH-1:0]       in_last,
    output logic                    out_last,
`endif
    input  logic                    mode,
    input  logic [SEL_WIDTH-1:0]    sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_WIDTH-1:0]    out_ch
);

    logic [WIDTH-1:0]     ch_data [NUM_CH];
    logic                 load;
    logic                 grant_any;
    logic [SEL_WIDTH-1:0] grant_idx;
    logic [NUM_CH-1:0]    grant;
    logic                 in_xfer;
    logic [SEL_WIDTH-1:0] rr_ptr;
    logic [SEL_WIDTH-1:0] ptr_next;
    logic                 ptr_adv;

`ifdef STREAM_MUX_LAST_LOCK_EN
    logic                 lock;
    logic [SEL_WIDTH-1:0] lock_ch;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    assign load = !out_valid || out_ready;

    always_comb begin : p_grant
        int                   idx;
        logic [SEL_WIDTH-1:0] cand;
        idx       = 0;
        cand      = '0;
        grant_any = 1'b0;
        grant_idx = '0;
`ifdef STREAM_MUX_LAST_LOCK_EN
        if (lock) begin
            grant_any = 1'b1;
            grant_idx = lock_ch;
        end else
`endif
        if (!mode) begin
            if (int'(sel) < NUM_CH) begin
                grant_any = 1'b1;
                grant_idx = sel;
            end
        end else begin
            // Upward search with wrap, starting at the channel after the last winner.
            for (int k = 0; k < NUM_CH; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_CH) idx = idx - NUM_CH;
                cand = SEL_WIDTH'(idx);
                if (!grant_any && in_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_CH; i++)
            grant[i] = grant_any && (grant_idx == SEL_WIDTH'(i));
    end

    assign in_ready = rst_n ? (grant & {NUM_CH{load}}) : '0;
    assign in_xfer  = |(in_ready & in_valid);
    assign ptr_next = (grant_idx == SEL_WIDTH'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;

`ifdef STREAM_MUX_LAST_LOCK_EN
    assign ptr_adv = in_xfer && mode && in_last[grant_idx];
`else
    assign ptr_adv = in_xfer && mode;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else begin
            if (in_xfer) begin
                out_valid <= 1'b1;
                out_data  <= ch_data[grant_idx];
                out_ch    <= grant_idx;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (ptr_adv) rr_ptr <= ptr_next;
        end
    end

`ifdef STREAM_MUX_LAST_LOCK_EN
    // A non-final beat pins the grant to its channel until that channel's last beat passes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock     <= 1'b0;
            lock_ch  <= '0;
            out_last <= 1'b0;
        end else if (in_xfer) begin
            lock     <= !in_last[grant_idx];
            lock_ch  <= grant_idx;
            out_last <= in_last[grant_idx];
        end
    end
`endif

endmodule

// File: tb/tb_stream_mux_nch.sv
// tb_stream_mux_nch: scoreboard bench for stream_mux_nch (4-channel main instance, 3-channel
// instance for the out-of-range select case).
module tb_stream_mux_nch;
    localparam int W  = 16;
    localparam int N  = 4;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N*W-1:0] in_data;
    logic [N-1:0]  in_valid, in_ready;
    logic          mode;
    logic [SW-1:0] sel;
    logic [W-1:0]  out_data;
    logic          out_valid, out_ready;
    logic [SW-1:0] out_ch;
    logic [N-1:0]  in_last;

    logic [23:0]   in_data3;
    logic [2:0]    in_valid3, in_ready3;
    logic [1:0]    sel3;
    logic [7:0]    out_data3;
    logic          out_valid3;
    logic [1:0]    out_ch3;
    logic [2:0]    in_last3;
`ifdef STREAM_MUX_LAST_LOCK_EN
    logic          out_last, out_last3;
`endif

    stream_mux_nch #(.WIDTH(W), .NUM_CH(N)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef STREAM_MUX_LAST_LOCK_EN
        .in_last(in_last), .out_last(out_last),
`endif
        .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_ch(out_ch)
    );

    stream_mux_nch #(.WIDTH(8), .NUM_CH(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
`ifdef STREAM_MUX_LAST_LOCK_EN
        .in_last(in_last3), .out_last(out_last3),
`endif
        .mode(1'b0), .sel(sel3), .out_data(out_data3), .out_valid(out_valid3),
        .out_ready(1'b1), .out_ch(out_ch3)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SW-1:0] ch;
        logic [W-1:0]  data;
        logic          last;
    } beat_t;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int ch, input logic [W-1:0] d, input logic last);
        beat_t b;
        b.ch   = SW'(ch);
        b.data = d;
        b.last = last;
        sb.push_back(b);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] onehot(input int c);
        logic [N-1:0] v;
        v = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    function automatic logic [W-1:0] pattern(input int c);
        return W'(16'h1111 * (c + 1));
    endfunction

    task automatic drain();
        in_valid = '0;
        repeat (2) step();
        @(negedge clk);
        check("drain_sb_empty", sb.size(), 0);
        check("drain_out_valid", out_valid, 0);
        step();
    endtask

    // Output-side scoreboard: every output transfer must match the oldest expected beat.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            beat_t e;
            check("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_ch", out_ch, e.ch);
                check("out_data", out_data, e.data);
`ifdef STREAM_MUX_LAST_LOCK_EN
                check("out_last", out_last, e.last);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq_rr [5] = '{0, 1, 2, 3, 0};
        int seq_sp [4] = '{1, 3, 1, 3};

        in_data   = {pattern(3), pattern(2), pattern(1), pattern(0)};
        in_valid  = '1;
        in_last   = '1;
        mode      = 1'b0;
        sel       = '0;
        out_ready = 1'b1;
        in_data3  = {8'h33, 8'h22, 8'h11};
        in_valid3 = '1;
        in_last3  = '1;
        sel3      = 2'd3;

        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_in_ready", in_ready, 0);

        // Fixed select
        step();
        rst_n = 1'b1;
        sel   = 2'd2;
        for (int k = 0; k < 4; k++) begin
            push(2, 16'h3333, 1'b1);
            @(negedge clk);
            check("fix_in_ready", in_ready, 4'b0100);
            step();
        end
        sel = 2'd0;
        for (int k = 0; k < 2; k++) begin
            push(0, 16'h1111, 1'b1);
            @(negedge clk);
            check("fix_sel0_in_ready", in_ready, 4'b0001);
            step();
        end
        in_valid = '0;
        @(negedge clk);
        check("fix_ready_no_valid", in_ready, 4'b0001);
        step();
        drain();

        // Round-robin, all valid
        mode     = 1'b1;
        in_valid = '1;
        for (int k = 0; k < 5; k++) begin
            push(seq_rr[k], pattern(seq_rr[k]), 1'b1);
            @(negedge clk);
            check("rr_in_ready", in_ready, onehot(seq_rr[k]));
            if (k > 0) check("rr_no_bubble", out_valid, 1);
            step();
        end
        drain();

        // Round-robin, sparse
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            push(seq_sp[k], pattern(seq_sp[k]), 1'b1);
            @(negedge clk);
            check("rr_sparse_in_ready", in_ready, onehot(seq_sp[k]));
            step();
        end
        drain();

        // Back-pressure
        mode     = 1'b0;
        sel      = 2'd1;
        in_valid = 4'b0010;
        push(1, 16'h2222, 1'b1);
        @(negedge clk);
        check("bp_first_ready", in_ready, 4'b0010);
        step();
        out_ready = 1'b0;
        in_data[W +: W] = 16'hBEEF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, 16'h2222);
            check("bp_in_ready", in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        push(1, 16'hBEEF, 1'b1);
        @(negedge clk);
        check("bp_release_ready", in_ready, 4'b0010);
        step();
        in_data[W +: W] = pattern(1);
        drain();

        // Reset mid-stream: a ch2 beat is held, then discarded
        mode      = 1'b1;
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        @(negedge clk);
        check("rst_pre_ready", in_ready, 4'b0100);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", out_valid, 0);
        check("rst_async_data", out_data, 0);
        check("rst_async_ch", out_ch, 0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = '1;
        push(0, 16'h1111, 1'b1);
        @(negedge clk);
        check("rst_rr_first", in_ready, 4'b0001);
        step();
        drain();

        // Out-of-range select on a 3-channel instance
        @(negedge clk);
        check("oor_in_ready", in_ready3, 0);
        check("oor_out_valid", out_valid3, 0);
        step();
        sel3 = 2'd2;
        @(negedge clk);
        check("sel3_in_ready", in_ready3, 3'b100);
        step();
        @(negedge clk);
        check("sel3_out_valid", out_valid3, 1);
        check("sel3_out_ch", out_ch3, 2);
        check("sel3_out_data", out_data3, 8'h33);
        step();

`ifdef STREAM_MUX_LAST_LOCK_EN
        // Packet lock: ch0 three-beat packet while ch1 waits
        mode     = 1'b0;
        sel      = 2'd0;
        in_valid = 4'b0011;
        in_last  = 4'b1110;
        push(0, 16'h1111, 1'b0);
        @(negedge clk);
        check("lock_b1_ready", in_ready, 4'b0001);
        step();
        sel  = 2'd1;
        mode = 1'b1;
        push(0, 16'h1111, 1'b0);
        @(negedge clk);
        check("lock_b2_ready", in_ready, 4'b0001);
        step();
        in_last = '1;
        push(0, 16'h1111, 1'b1);
        @(negedge clk);
        check("lock_b3_ready", in_ready, 4'b0001);
        step();
        push(1, 16'h2222, 1'b1);
        @(negedge clk);
        check("lock_release_ready", in_ready, 4'b0010);
        step();
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
